mem_burst_ctrl: RTL
===================

Name: mem_burst_ctrl

Overview:
- Burst master placed directly upstream of the single-port synchronous memory. It converts one command (start address, beat count, direction) into a sequence of single-beat memory accesses.
- Write bursts take data from a valid/ready stream. Read bursts return data on a valid/ready stream.
- Absorbs the memory's 1-cycle registered read latency and consumer backpressure through a small credit-managed response FIFO.
- Never asserts memory read and write in the same cycle.

Parameters:
- ADDR_WIDTH, 8, memory address width; also the width of the burst length field.
- DATA_WIDTH, 8, data word width.
- RESP_DEPTH, 4, read response FIFO depth (power of 2, >=4 for full read throughput).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start address.
- cmd_len  in  ADDR_WIDTH  beats minus 1 (0 means 1 beat; max 2^ADDR_WIDTH beats).
- wr_valid  in  1  write data offered.
- wr_ready  out  1  high only in WR.
- wr_data  in  DATA_WIDTH  write beat.
- rd_valid  out  1  read beat available (FIFO not empty).
- rd_ready  in  1  consumer accepts.
- rd_data  out  DATA_WIDTH  FIFO head.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a burst completes.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_addr  out  ADDR_WIDTH  to memory addr.
- mem_wdata  out  DATA_WIDTH  to memory data_in.
- mem_rdata  in  DATA_WIDTH  from memory data_out.

Behaviour:
- Reset: state IDLE; mem_read, mem_write, mem_addr, mem_wdata, done, rd_valid all 0; FIFO emptied; credit counter 0.
- Reset mid-burst abandons the burst with no done pulse. A write already registered onto the mem_* outputs may still complete at that edge.
- States: IDLE, WR, RD, DRAIN.
  - IDLE: on cmd_valid latch addr, remaining = cmd_len, and direction; go to WR or RD.
  - WR: on wr_valid && wr_ready, register mem_write=1, mem_addr=addr, mem_wdata=wr_data for the next cycle, then addr++. If remaining==0, go to IDLE and pulse done in the same cycle mem_write is high for the last beat; otherwise remaining--. mem_write returns to 0 in any cycle without a handshake.
  - RD: issue when credits < RESP_DEPTH. An issue registers mem_read=1 and mem_addr=addr for the next cycle, increments credits, and does addr++. After the last issue (remaining==0) go to DRAIN; otherwise remaining--.
  - DRAIN: wait until credits==0, then pulse done and go to IDLE.
- Read pipeline:
  - mem_read is high in cycle k and the memory captures at the end of k.
  - A registered pending flag pushes mem_rdata into the FIFO at the end of k+1.
  - rd_valid is first high in cycle k+2.
  - Minimum read latency from issue decision to rd_valid is 3 cycles.
- Credits: +1 on issue, -1 on rd_valid && rd_ready; both in one cycle leaves the count unchanged. Credits never exceed RESP_DEPTH, so a push never meets a full FIFO.
- FIFO: a simultaneous push and pop is legal. Data order matches address order. rd_data is stable while rd_valid && !rd_ready.
- Address: increments modulo 2^ADDR_WIDTH. A burst crossing the top address wraps to 0.
- cmd_valid outside IDLE is ignored (cmd_ready=0). Burst parameters are captured only at the handshake.
- Throughput: 1 write per cycle with continuous wr_valid. 1 read per cycle with continuous rd_ready.
- Invariants (bench asserts these): mem_read && mem_write never both 1; credits ≤ RESP_DEPTH; done is never high for two consecutive cycles.

Decomposition:
- Package mem_burst_pkg: state enum (IDLE, WR, RD, DRAIN) and the default width constants.
- Sub-module mem_resp_fifo: parameterized DEPTH/WIDTH synchronous FIFO, first-word-fall-through, push/pop/full/empty, with synchronous reset.
- Top level holds the FSM, address and length counters, credit counter, pending flag, and the registered mem_* outputs.

Test Plan:
- Single write then read: write cmd addr=0x10 len=0, wr_data=0xA5. Then read cmd addr=0x10 len=0 with rd_ready=1. Expect mem_write for 1 cycle at 0x10, done pulse, then rd_data=0xA5 exactly 3 cycles after the read issue, and a second done.
- Streaming burst: write 16 beats 0x00..0x0F from addr 0x20, then read 16 with rd_ready held high. Expect rd_valid high 16 consecutive cycles with ascending data, and no mem_read && mem_write overlap.
- Backpressure: read 8 beats with rd_ready=0 for 10 cycles. Expect exactly 4 mem_read pulses, then a stall. After rd_ready=1, all 8 beats arrive in order and rd_data holds steady while stalled.
- Wrap: write len=3 at addr 0xFE with data 1..4. Expect writes to 0xFE, 0xFF, 0x00, 0x01; read-back matches.
- Reset mid-read: assert reset during a 10-beat read after 3 issues. Expect rd_valid=0, busy=0, and cmd_ready=1 the next cycle with no done pulse; a following 1-beat read works normally.
- Command while busy and write gaps: during a write burst, pulse cmd_valid and toggle wr_valid randomly. Expect the command ignored, mem_write only on handshake cycles, and done after exactly len+1 beats.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state type and default widths for the burst controller
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int RESP_DEPTH_DEF = 4;
endpackage

// File: rtl/mem_burst_ctrl_if.sv
// mem_burst_ctrl_if: command, write stream, read stream and memory bus of the burst controller
interface mem_burst_ctrl_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH-1:0] cmd_len;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, mem_rdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_resp_fifo.sv
// mem_resp_fifo: first-word-fall-through synchronous FIFO holding read responses
module mem_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign rdata = mem_q[rp_q[AW-1:0]];
  always_comb begin
    wp_d = (push && !full) ? wp_q + 1'b1 : wp_q;
    rp_d = (pop && !empty) ? rp_q + 1'b1 : rp_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
    if (push && !full) mem_q[wp_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst master turning one command into single-beat memory accesses with credit-managed read returns
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF
) (
  input logic clk,
  input logic reset,
  mem_burst_ctrl_if.master bus
);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rem_q, rem_d, mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [CW-1:0] credits_q, credits_d;
  logic pend_q, mem_read_q, mem_read_d, mem_write_q, mem_write_d, done_q, done_d;
  logic issue, pop, fifo_full, fifo_empty;
  assign pop = !fifo_empty && bus.rd_ready;
  assign issue = (state_q == RD) && (credits_q < CW'(RESP_DEPTH)) && !fifo_full;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    done_d = 1'b0;
    credits_d = credits_q + CW'(issue) - CW'(pop);
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        addr_d = bus.cmd_addr;
        rem_d = bus.cmd_len;
        state_d = bus.cmd_write ? WR : RD;
      end
      WR: if (bus.wr_valid) begin
        mem_write_d = 1'b1;
        mem_addr_d = addr_q;
        mem_wdata_d = bus.wr_data;
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == '0) ? IDLE : WR;
        done_d = rem_q == '0;
      end
      RD: if (issue) begin
        mem_read_d = 1'b1;
        mem_addr_d = addr_q;
        addr_d = addr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = (rem_q == '0) ? DRAIN : RD;
      end
      DRAIN: if (credits_q == '0) begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      credits_q <= '0;
      pend_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      credits_q <= credits_d;
      pend_q <= mem_read_q;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      done_q <= done_d;
    end
  end
  mem_resp_fifo #(.DEPTH(RESP_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(pend_q),
    .pop(pop),
    .wdata(bus.mem_rdata),
    .rdata(bus.rd_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.wr_ready = state_q == WR;
  assign bus.busy = state_q != IDLE;
  assign bus.rd_valid = !fifo_empty;
  assign bus.done = done_q;
  assign bus.mem_read = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule
